// File: rtl/tlb_pkg.sv
// tlb_pkg
//   Shared definitions for the instruction TLB array: the entry record,
//   {U,X,W,R} permission bit positions, the megapage split point and the
//   VPN compare rule used by lookup, fill-match and flush.
//   Entry field widths are fixed here (Sv32: VPN 20, PPN 22, ASID 9).
//   Instantiating modules take their width parameters from these constants.
package tlb_pkg;

  localparam int TLB_VPN_W  = 20;
  localparam int TLB_PPN_W  = 22;
  localparam int TLB_ASID_W = 9;

  // A megapage covers 2^MEGA_LSB base pages; only VPN bits above this compare.
  localparam int MEGA_LSB = 10;

  typedef enum int {
    PERM_R = 0,
    PERM_W = 1,
    PERM_X = 2,
    PERM_U = 3
  } perm_bit_e;

  typedef struct packed {
    logic                  valid;
    logic                  is_global;
    logic                  mega;
    logic [TLB_ASID_W-1:0] asid;
    logic [TLB_VPN_W-1:0]  vpn;
    logic [TLB_PPN_W-1:0]  ppn;
    logic [3:0]            perm;
  } tlb_entry_t;

  // VPN compare honouring the megapage flag; validity and ASID are not checked.
  function automatic logic vpn_match(input tlb_entry_t e, input logic [TLB_VPN_W-1:0] vpn);
    if (e.mega)
      return e.vpn[TLB_VPN_W-1:MEGA_LSB] == vpn[TLB_VPN_W-1:MEGA_LSB];
    return e.vpn == vpn;
  endfunction

endpackage

// File: rtl/tlb_prio_enc.sv
// tlb_prio_enc
//   First-one encoder over a request vector.
//   req   : request bits, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   any   : at least one bit set
//   multi : two or more bits set
module tlb_prio_enc #(
  parameter int N  = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign any = |req;

  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/itlb_cam_assoc.sv
// itlb_cam_assoc
//   Fully-associative Sv32 instruction TLB with ASID/global tagging,
//   megapage matching, hit-aware refill with round-robin victim choice and
//   selective/full flush.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     lookup_valid/vpn/asid         translation request (1-cycle latency)
//     rsp_valid/hit/miss/multihit   registered response status
//     rsp_ppn/perm/idx              registered response data (0 on miss)
//     fill_valid/vpn/asid/ppn/perm  new translation from the walker
//     fill_global/fill_mega         entry attributes
//     flush_valid/use_vpn/use_asid  SFENCE.VMA request and qualifiers
//     flush_vpn/flush_asid          flush qualifier values
module itlb_cam_assoc
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int VPN_W   = TLB_VPN_W,
  parameter int PPN_W   = TLB_PPN_W,
  parameter int ASID_W  = TLB_ASID_W,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              lookup_valid,
  input  logic [VPN_W-1:0]  lookup_vpn,
  input  logic [ASID_W-1:0] lookup_asid,

  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_miss,
  output logic              rsp_multihit,
  output logic [PPN_W-1:0]  rsp_ppn,
  output logic [3:0]        rsp_perm,
  output logic [IDX_W-1:0]  rsp_idx,

  input  logic              fill_valid,
  input  logic [VPN_W-1:0]  fill_vpn,
  input  logic [ASID_W-1:0] fill_asid,
  input  logic [PPN_W-1:0]  fill_ppn,
  input  logic [3:0]        fill_perm,
  input  logic              fill_global,
  input  logic              fill_mega,

  input  logic              flush_valid,
  input  logic              flush_use_vpn,
  input  logic              flush_use_asid,
  input  logic [VPN_W-1:0]  flush_vpn,
  input  logic [ASID_W-1:0] flush_asid
);

  tlb_entry_t         tlb_q [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic [ENTRIES-1:0] lkp_match;
  logic [ENTRIES-1:0] flush_clr;
  logic [ENTRIES-1:0] valid_pf;
  logic [ENTRIES-1:0] fill_match;

  logic [IDX_W-1:0]   lkp_idx, fm_idx, inv_idx, fill_idx;
  logic               lkp_any, lkp_multi, fm_any, inv_any, rr_adv;
  logic               unused_fm_multi, unused_inv_multi;

  tlb_entry_t         hit_e;
  logic [PPN_W-1:0]   hit_ppn;

  // Lookup sees pre-update contents; fill-match sees post-flush validity.
  always_comb begin
    lkp_match  = '0;
    flush_clr  = '0;
    valid_pf   = '0;
    fill_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lkp_match[i]  = tlb_q[i].valid
                      && (tlb_q[i].is_global || tlb_q[i].asid == lookup_asid)
                      && vpn_match(tlb_q[i], lookup_vpn);
      flush_clr[i]  = flush_valid
                      && (!flush_use_vpn  || vpn_match(tlb_q[i], flush_vpn))
                      && (!flush_use_asid || (!tlb_q[i].is_global && tlb_q[i].asid == flush_asid));
      valid_pf[i]   = tlb_q[i].valid && !flush_clr[i];
      fill_match[i] = valid_pf[i]
                      && (tlb_q[i].is_global || tlb_q[i].asid == fill_asid)
                      && vpn_match(tlb_q[i], fill_vpn);
    end
  end

  tlb_prio_enc #(.N(ENTRIES), .IW(IDX_W)) u_lkp_enc (
    .req   (lkp_match),
    .idx   (lkp_idx),
    .any   (lkp_any),
    .multi (lkp_multi)
  );

  tlb_prio_enc #(.N(ENTRIES), .IW(IDX_W)) u_fill_enc (
    .req   (fill_match),
    .idx   (fm_idx),
    .any   (fm_any),
    .multi (unused_fm_multi)
  );

  tlb_prio_enc #(.N(ENTRIES), .IW(IDX_W)) u_inv_enc (
    .req   (~valid_pf),
    .idx   (inv_idx),
    .any   (inv_any),
    .multi (unused_inv_multi)
  );

  // Refill an existing translation in place, else the first free slot,
  // else evict at rr_ptr (which only advances when actually consumed).
  always_comb begin
    fill_idx = rr_ptr;
    rr_adv   = 1'b0;
    if (fm_any)       fill_idx = fm_idx;
    else if (inv_any) fill_idx = inv_idx;
    else              rr_adv   = fill_valid;
  end

  always_comb begin
    hit_e   = tlb_q[lkp_idx];
    hit_ppn = hit_e.ppn;
    if (hit_e.mega)
      hit_ppn = {hit_e.ppn[PPN_W-1:MEGA_LSB], lookup_vpn[MEGA_LSB-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tlb_q[i].valid <= 1'b0;
      rr_ptr       <= '0;
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_miss     <= 1'b0;
      rsp_multihit <= 1'b0;
      rsp_ppn      <= '0;
      rsp_perm     <= '0;
      rsp_idx      <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush_clr[i]) tlb_q[i].valid <= 1'b0;
      end
      // Later non-blocking write wins, so a fill lands on top of the flush.
      if (fill_valid) begin
        tlb_q[fill_idx].valid     <= 1'b1;
        tlb_q[fill_idx].is_global <= fill_global;
        tlb_q[fill_idx].mega      <= fill_mega;
        tlb_q[fill_idx].asid      <= fill_asid;
        tlb_q[fill_idx].vpn       <= fill_vpn;
        tlb_q[fill_idx].ppn       <= fill_ppn;
        tlb_q[fill_idx].perm      <= fill_perm;
      end
      if (rr_adv) rr_ptr <= rr_ptr + IDX_W'(1);

      rsp_valid    <= lookup_valid;
      rsp_hit      <= lookup_valid && lkp_any;
      rsp_miss     <= lookup_valid && !lkp_any;
      rsp_multihit <= lookup_valid && lkp_multi;
      rsp_ppn      <= (lookup_valid && lkp_any) ? hit_ppn    : '0;
      rsp_perm     <= (lookup_valid && lkp_any) ? hit_e.perm : '0;
      rsp_idx      <= (lookup_valid && lkp_any) ? lkp_idx    : '0;
    end
  end

endmodule

// File: tb/tb_itlb_cam_assoc.sv
module tb_itlb_cam_assoc;

  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;

  logic        clk, rst;
  logic        lookup_valid;
  logic [19:0] lookup_vpn;
  logic [8:0]  lookup_asid;
  logic        rsp_valid, rsp_hit, rsp_miss, rsp_multihit;
  logic [21:0] rsp_ppn;
  logic [3:0]  rsp_perm;
  logic [IDX_W-1:0] rsp_idx;
  logic        fill_valid;
  logic [19:0] fill_vpn;
  logic [8:0]  fill_asid;
  logic [21:0] fill_ppn;
  logic [3:0]  fill_perm;
  logic        fill_global, fill_mega;
  logic        flush_valid, flush_use_vpn, flush_use_asid;
  logic [19:0] flush_vpn;
  logic [8:0]  flush_asid;

  itlb_cam_assoc #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn), .lookup_asid(lookup_asid),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_miss(rsp_miss),
    .rsp_multihit(rsp_multihit), .rsp_ppn(rsp_ppn), .rsp_perm(rsp_perm), .rsp_idx(rsp_idx),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_asid(fill_asid),
    .fill_ppn(fill_ppn), .fill_perm(fill_perm), .fill_global(fill_global), .fill_mega(fill_mega),
    .flush_valid(flush_valid), .flush_use_vpn(flush_use_vpn), .flush_use_asid(flush_use_asid),
    .flush_vpn(flush_vpn), .flush_asid(flush_asid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid [ENTRIES];
  logic        m_glb   [ENTRIES];
  logic        m_mega  [ENTRIES];
  logic [8:0]  m_asid  [ENTRIES];
  logic [19:0] m_vpn   [ENTRIES];
  logic [21:0] m_ppn   [ENTRIES];
  logic [3:0]  m_perm  [ENTRIES];
  int          m_rr;

  logic        e_valid = 0, e_hit = 0, e_miss = 0, e_multi = 0;
  logic [21:0] e_ppn = 0;
  logic [3:0]  e_perm = 0;
  int          e_idx = 0;

  function automatic logic m_vpn_eq(input int i, input logic [19:0] vpn);
    if (m_mega[i]) return (m_vpn[i] / 1024) == (vpn / 1024);
    return m_vpn[i] == vpn;
  endfunction

  function automatic logic m_hit(input int i, input logic [19:0] vpn, input logic [8:0] asid);
    return m_valid[i] && (m_glb[i] || m_asid[i] == asid) && m_vpn_eq(i, vpn);
  endfunction

  always @(posedge clk) begin : model
    int cnt, first, tgt;
    logic clr;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_rr = 0;
      e_valid = 0; e_hit = 0; e_miss = 0; e_multi = 0; e_ppn = 0; e_perm = 0; e_idx = 0;
    end else begin
      cnt = 0; first = -1;
      for (int i = 0; i < ENTRIES; i++)
        if (m_hit(i, lookup_vpn, lookup_asid)) begin
          cnt++;
          if (first < 0) first = i;
        end
      e_valid = lookup_valid;
      e_hit   = lookup_valid && cnt > 0;
      e_miss  = lookup_valid && cnt == 0;
      e_multi = lookup_valid && cnt > 1;
      if (e_hit) begin
        e_idx  = first;
        e_perm = m_perm[first];
        e_ppn  = m_mega[first] ? (m_ppn[first] - (m_ppn[first] % 1024) + (lookup_vpn % 1024))
                               : m_ppn[first];
      end else begin
        e_idx = 0; e_perm = 0; e_ppn = 0;
      end
      if (flush_valid)
        for (int i = 0; i < ENTRIES; i++) begin
          clr = 1'b1;
          if (flush_use_vpn && !m_vpn_eq(i, flush_vpn)) clr = 1'b0;
          if (flush_use_asid && (m_glb[i] || m_asid[i] != flush_asid)) clr = 1'b0;
          if (clr) m_valid[i] = 1'b0;
        end
      if (fill_valid) begin
        tgt = -1;
        for (int i = 0; i < ENTRIES; i++)
          if (tgt < 0 && m_hit(i, fill_vpn, fill_asid)) tgt = i;
        for (int i = 0; i < ENTRIES; i++)
          if (tgt < 0 && !m_valid[i]) tgt = i;
        if (tgt < 0) begin
          tgt  = m_rr;
          m_rr = (m_rr + 1) % ENTRIES;
        end
        m_valid[tgt] = 1'b1; m_glb[tgt] = fill_global; m_mega[tgt] = fill_mega;
        m_asid[tgt] = fill_asid; m_vpn[tgt] = fill_vpn; m_ppn[tgt] = fill_ppn; m_perm[tgt] = fill_perm;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp.valid", rsp_valid, e_valid);
      chk("cmp.hit",   rsp_hit,   e_hit);
      chk("cmp.miss",  rsp_miss,  e_miss);
      chk("cmp.multi", rsp_multihit, e_multi);
      chk("cmp.ppn",   rsp_ppn,   e_ppn);
      chk("cmp.perm",  rsp_perm,  e_perm);
      chk("cmp.idx",   rsp_idx,   e_idx);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    lookup_valid = 0; lookup_vpn = 0; lookup_asid = 0;
    fill_valid = 0; fill_vpn = 0; fill_asid = 0; fill_ppn = 0; fill_perm = 0;
    fill_global = 0; fill_mega = 0;
    flush_valid = 0; flush_use_vpn = 0; flush_use_asid = 0; flush_vpn = 0; flush_asid = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                          input logic [3:0] perm, input logic g, input logic m);
    fill_valid = 1; fill_vpn = vpn; fill_asid = asid; fill_ppn = ppn;
    fill_perm = perm; fill_global = g; fill_mega = m;
  endtask

  task automatic set_flush(input logic uv, input logic ua, input logic [19:0] vpn, input logic [8:0] asid);
    flush_valid = 1; flush_use_vpn = uv; flush_use_asid = ua; flush_vpn = vpn; flush_asid = asid;
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                      input logic [3:0] perm, input logic g, input logic m);
    set_fill(vpn, asid, ppn, perm, g, m);
    cyc();
    idle();
  endtask

  task automatic flush(input logic uv, input logic ua, input logic [19:0] vpn, input logic [8:0] asid);
    set_flush(uv, ua, vpn, asid);
    cyc();
    idle();
  endtask

  task automatic lookup(input logic [19:0] vpn, input logic [8:0] asid);
    lookup_valid = 1; lookup_vpn = vpn; lookup_asid = asid;
    cyc();
    idle();
  endtask

  task automatic expect_rsp(input string nm, input logic hit, input logic multi,
                            input logic [21:0] ppn, input logic [3:0] perm, input int idx);
    chk({nm, ".valid"}, rsp_valid, 1);
    chk({nm, ".hit"},   rsp_hit, hit);
    chk({nm, ".miss"},  rsp_miss, !hit);
    chk({nm, ".multi"}, rsp_multihit, multi);
    chk({nm, ".ppn"},   rsp_ppn, ppn);
    chk({nm, ".perm"},  rsp_perm, perm);
    chk({nm, ".idx"},   rsp_idx, idx);
    chk({nm, ".model_hit"}, e_hit, hit);
    chk({nm, ".model_ppn"}, e_ppn, ppn);
  endtask

  task automatic expect_miss(input string nm);
    expect_rsp(nm, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    rst = 1;
    lookup_valid = 1; lookup_vpn = 20'h12345; lookup_asid = 9'd1;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst.valid", rsp_valid, 0);
    chk("rst.hit",   rsp_hit, 0);
    chk("rst.miss",  rsp_miss, 0);
    chk("rst.ppn",   rsp_ppn, 0);
    rst = 0;
    idle();
    cyc();

    lookup(20'h12345, 1);                       expect_miss("cold_miss");

    fill(20'h12345, 1, 22'h0ABCD, 4'hB, 0, 0);
    lookup(20'h12345, 1);                       expect_rsp("fill_hit", 1, 0, 22'h0ABCD, 4'hB, 0);
    lookup(20'h12345, 2);                       expect_miss("asid_miss");
    fill(20'h12345, 1, 22'h0ABCD, 4'hB, 1, 0);
    lookup(20'h12345, 2);                       expect_rsp("global_hit", 1, 0, 22'h0ABCD, 4'hB, 0);

    fill(20'h12000, 1, 22'h3FC00, 4'hA, 0, 1);
    lookup(20'h123FF, 1);                       expect_rsp("mega_hit", 1, 0, 22'h3FFFF, 4'hA, 1);
    lookup(20'h12345, 1);                       expect_rsp("mega_overlap", 1, 1, 22'h0ABCD, 4'hB, 0);

    flush(0, 0, 0, 0);
    lookup(20'h12345, 1);                       expect_miss("full_flush_a");
    lookup(20'h123FF, 1);                       expect_miss("full_flush_b");

    for (int k = 0; k < ENTRIES + 3; k++) fill(20'h100 + 20'(k), 3, 22'h200 + 22'(k), 4'h1, 0, 0);
    lookup(20'h108, 3);                         expect_rsp("rr_0", 1, 0, 22'h208, 4'h1, 0);
    lookup(20'h109, 3);                         expect_rsp("rr_1", 1, 0, 22'h209, 4'h1, 1);
    lookup(20'h10A, 3);                         expect_rsp("rr_2", 1, 0, 22'h20A, 4'h1, 2);
    lookup(20'h100, 3);                         expect_miss("evicted_0");
    lookup(20'h101, 3);                         expect_miss("evicted_1");
    lookup(20'h102, 3);                         expect_miss("evicted_2");
    lookup(20'h103, 3);                         expect_rsp("kept_3", 1, 0, 22'h203, 4'h1, 3);
    fill(20'h105, 3, 22'h355, 4'h1, 0, 0);
    lookup(20'h105, 3);                         expect_rsp("refill_same_idx", 1, 0, 22'h355, 4'h1, 5);
    fill(20'h1FF, 3, 22'h3FF, 4'h1, 0, 0);
    lookup(20'h1FF, 3);                         expect_rsp("rr_unchanged", 1, 0, 22'h3FF, 4'h1, 3);
    lookup(20'h103, 3);                         expect_miss("evicted_3");

    flush(0, 0, 0, 0);
    fill(20'h00AAA, 1, 22'hA1, 4'h5, 1, 0);
    fill(20'h00BBB, 1, 22'hB1, 4'h5, 0, 0);
    flush(0, 1, 0, 1);
    lookup(20'h00AAA, 1);                       expect_rsp("asid_flush_global", 1, 0, 22'hA1, 4'h5, 0);
    lookup(20'h00BBB, 1);                       expect_miss("asid_flush_local");

    set_flush(0, 0, 0, 0);
    set_fill(20'h00CCC, 1, 22'hC1, 4'h3, 0, 0);
    cyc(); idle();
    lookup(20'h00CCC, 1);                       expect_rsp("flush_fill_same", 1, 0, 22'hC1, 4'h3, 0);
    lookup(20'h00AAA, 1);                       expect_miss("flush_fill_cleared");

    set_fill(20'h00DDD, 1, 22'hD1, 4'h3, 0, 0);
    lookup_valid = 1; lookup_vpn = 20'h00DDD; lookup_asid = 1;
    cyc(); idle();                              expect_miss("lookup_during_fill");
    lookup(20'h00DDD, 1);                       expect_rsp("lookup_after_fill", 1, 0, 22'hD1, 4'h3, 1);

    flush(0, 0, 0, 0);
    fill(20'h00EEE, 1, 22'hE1, 4'h1, 0, 0);
    fill(20'h00EEE, 2, 22'hE2, 4'h1, 0, 0);
    fill(20'h00EEE, 3, 22'hE3, 4'h1, 1, 0);
    lookup(20'h00EEE, 1);                       expect_rsp("multihit_a1", 1, 1, 22'hE1, 4'h1, 0);
    lookup(20'h00EEE, 2);                       expect_rsp("multihit_a2", 1, 1, 22'hE2, 4'h1, 1);
    lookup(20'h00EEE, 5);                       expect_rsp("global_only", 1, 0, 22'hE3, 4'h1, 2);

    fill(20'h12000, 4, 22'h3FC00, 4'h2, 0, 1);
    flush(1, 0, 20'h123FF, 0);
    lookup(20'h12000, 4);                       expect_miss("vpn_flush_mega");
    lookup(20'h00EEE, 1);                       expect_rsp("vpn_flush_other", 1, 1, 22'hE1, 4'h1, 0);

    flush(1, 1, 20'h00EEE, 2);
    lookup(20'h00EEE, 2);                       expect_rsp("vpn_asid_flush", 1, 0, 22'hE3, 4'h1, 2);

    rst = 1;
    set_fill(20'h00777, 1, 22'h77, 4'h1, 0, 0);
    lookup_valid = 1; lookup_vpn = 20'h00EEE; lookup_asid = 1;
    cyc(); idle();
    chk("rst_override.valid", rsp_valid, 0);
    chk("rst_override.hit",   rsp_hit, 0);
    rst = 0;
    lookup(20'h00EEE, 1);                       expect_miss("post_rst_a");
    lookup(20'h00777, 1);                       expect_miss("post_rst_b");

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
